checkout_accumulator: RTL
=========================

# checkout_accumulator

Parametrised successor of the weigh-and-price calculator core of the electronic-scale design. Registers the unit product weight × price, keeps a running total with an item history so the last entries can be undone, and converts the total to packed BCD for the segment-message blocks. It sits between the debounced key pulses and the display drivers. Widths, history depth and BCD digit count are generic.

## Interface
- `W_WT`, 4, weight input width
- `W_PR`, 4, price input width
- `SUM_W`, 16, total width; must be ≥ `W_WT+W_PR`
- `DEPTH`, 8, history entries (max items)
- `DIGITS`, 5, BCD digits; must satisfy 10^DIGITS > 2^SUM_W−1
- `clk100mhz` in 1: single clock for the block.
- `reset` in 1: asynchronous, active-high.
- `weight` in `W_WT`: current weight.
- `price` in `W_PR`: current unit price.
- `add` in 1: one-cycle pulse, already debounced; push current product.
- `undo` in 1: one-cycle pulse; remove last item.
- `clear` in 1: one-cycle pulse; empty total and history.
- `single` out `W_WT+W_PR`: registered weight × price.
- `sum` out `SUM_W`: running total.
- `count` out `$clog2(DEPTH+1)`: items held.
- `sum_bcd` out `4*DIGITS`: BCD of `sum`, least significant digit in [3:0].
- `bcd_valid` out 1: `sum_bcd` matches current `sum`.
- `reject` out 1: one-cycle pulse when a request is refused.

## Operation
- `single` <= weight*price every cycle, unsigned, full width; no truncation.
- Priority per cycle: clear > undo > add. Lower-priority requests in the same cycle are dropped silently; they do not raise `reject`.
- clear: `sum`=0, `count`=0. History contents are don't-care.
- undo:
  - If `count`>0: `sum` -= hist[count−1], then `count`−1.
  - If `count`=0: no change, `reject`=1.
- add: operand is the `single` register value in that cycle, zero-extended to `SUM_W`.
  - Refused with `reject`=1 if `count`=DEPTH (full) or `sum+single` > 2^SUM_W−1 (overflow). State is unchanged.
  - Otherwise hist[count] <= single, `sum` += single, `count`+1.
  - A product of 0 is a valid item: it is counted and can be undone.
- History is a LIFO register array of DEPTH × (W_WT+W_PR). `sum` always equals the sum of hist[0..count−1].
- BCD converter: sequential shift-add-3 (double-dabble) FSM.
  - IDLE: `bcd_valid`=1. Any change of `sum` → LOAD.
  - LOAD: latch `sum` into the shift register, clear digits, `bcd_valid`=0 → SHIFT.
  - SHIFT: run SUM_W iterations (add-3 to each digit ≥5, then shift left 1), then → DONE.
  - DONE: write `sum_bcd`, `bcd_valid`=1 → IDLE.
  - A change of `sum` during SHIFT or DONE aborts and goes to LOAD. `sum_bcd` keeps its old value until DONE.

## Timing
- Reset values: `single`=0, `sum`=0, `count`=0, `sum_bcd`=0, `bcd_valid`=1, `reject`=0, FSM=IDLE.
- `single` latency: 1 cycle after weight/price change. Weight and price must be stable ≥1 cycle before `add`.
- `sum`, `count` and `reject` update on the clock edge that samples the request: 1-cycle latency.
- `bcd_valid` falls the cycle after `sum` changes. `sum_bcd` is valid SUM_W+3 cycles after the `sum` update, absent further changes.
- Back-to-back requests on consecutive cycles are all honoured; no busy state on the accumulator path.
- Reset mid-conversion: FSM goes to IDLE with `sum_bcd`=0, consistent with `sum`=0.

## Structure
- Shared package `scale_pkg`: BCD digit type (4-bit), the FSM state enum (IDLE/LOAD/SHIFT/DONE) and the default parameter constants.
- Sub-module `bin2bcd_seq` (parameters SUM_W, DIGITS; ports clk100mhz, reset, bin, bcd, valid). Holds the double-dabble FSM.
- The top level holds the product register, the history array, the accumulator and the request arbitration.

## Test plan
- Reset, then weight=3, price=5, wait 1 cycle, `add` → `single`=15, `sum`=15, `count`=1, then `bcd_valid` rises with `sum_bcd`=0x00015 after 19 cycles.
- Add 15, then weight=9 price=9 add 81, then `undo` → `sum` 96 then 15, `count` 2 then 1. A second and third `undo` give `sum`=0, `count`=0, then `reject` pulse with no change.
- Nine adds of 225 (weight=15, price=15) with DEPTH=8 → `sum`=1800, `count`=8, ninth add gives `reject`, state unchanged.
- SUM_W=8: adds of 225 then 225 → second add `reject`, `sum`=225.
- `add`, `undo` and `clear` in the same cycle with `count`=3 → `sum`=0, `count`=0, no `reject`. `undo`+`add` with `count`=1 → undo only.
- `add` issued mid-conversion → conversion restarts, final `sum_bcd` equals the new sum. Assert `reset` during SHIFT → all outputs at their reset values.

Source files
------------

// File: rtl/scale_pkg.sv
// Shared types and default constants for the checkout accumulator and its BCD converter.
package scale_pkg;

    localparam int unsigned DEF_W_WT   = 4;
    localparam int unsigned DEF_W_PR   = 4;
    localparam int unsigned DEF_SUM_W  = 16;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_DIGITS = 5;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } bcd_state_t;

    // Double-dabble correction: a digit of 5 or more would overflow past 9 when doubled.
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-add-3), restarting whenever the input changes.
module bin2bcd_seq
    import scale_pkg::*;
#(
    parameter int unsigned SUM_W  = DEF_SUM_W,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic                  clk100mhz,
    input  logic                  reset,
    input  logic [SUM_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid
);

    localparam int unsigned IW = $clog2(SUM_W + 1);

    bcd_state_t          state_q, state_d;
    logic [SUM_W-1:0]    last_q, last_d;    // value of bin captured at the last LOAD
    logic [SUM_W-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] dig_q, dig_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic [4*DIGITS-1:0] adj;
    logic                changed;

    // Add-3 correction applied to every digit before each shift.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = add3(dig_q[4*i +: 4]);
        end
    end

    // Next-state and datapath control for the conversion FSM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        dig_d   = dig_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        changed = (bin != last_q);
        unique case (state_q)
            StIdle: begin
                if (changed) state_d = StLoad;
            end
            StLoad: begin
                last_d  = bin;
                shift_d = bin;
                dig_d   = '0;
                iter_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                if (changed) begin
                    state_d = StLoad;
                end else begin
                    {dig_d, shift_d} = {adj, shift_q} << 1;
                    iter_d = iter_q + 1'b1;
                    if (iter_q == IW'(SUM_W - 1)) state_d = StDone;
                end
            end
            StDone: begin
                if (changed) begin
                    state_d = StLoad;
                end else begin
                    bcd_d   = dig_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset leaves a result consistent with a zero input.
    always_ff @(posedge clk100mhz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= '0;
            shift_q <= '0;
            dig_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            dig_q   <= dig_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
        end
    end

    assign bcd   = bcd_q;
    assign valid = (state_q == StIdle);

endmodule

// File: rtl/checkout_accumulator.sv
// Weigh-and-price accumulator: product register, undoable item history, running total and BCD view.
module checkout_accumulator
    import scale_pkg::*;
#(
    parameter int unsigned W_WT   = DEF_W_WT,
    parameter int unsigned W_PR   = DEF_W_PR,
    parameter int unsigned SUM_W  = DEF_SUM_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic                         clk100mhz,
    input  logic                         reset,
    input  logic [W_WT-1:0]              weight,
    input  logic [W_PR-1:0]              price,
    input  logic                         add,
    input  logic                         undo,
    input  logic                         clear,
    output logic [W_WT+W_PR-1:0]         single,
    output logic [SUM_W-1:0]             sum,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [4*DIGITS-1:0]          sum_bcd,
    output logic                         bcd_valid,
    output logic                         reject
);

    localparam int unsigned PW    = W_WT + W_PR;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    single_q;
    logic [PW-1:0]    hist_q [DEPTH];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             reject_q, reject_d;
    logic             push;
    logic [IDX_W-1:0] push_idx, top_idx;
    logic [SUM_W:0]   add_total;

    // Product register, full width so no product is ever truncated.
    always_ff @(posedge clk100mhz or posedge reset) begin
        if (reset) single_q <= '0;
        else       single_q <= PW'(weight) * PW'(price);
    end

    assign push_idx = IDX_W'(count_q);
    // Garbage when count is 0, but only used on the non-empty undo path.
    assign top_idx  = IDX_W'(count_q - CW'(1));
    // One extra bit exposes overflow of the running total.
    assign add_total = {1'b0, sum_q} + {{(SUM_W + 1 - PW){1'b0}}, single_q};

    // Request arbitration: clear beats undo beats add; losers are dropped without reject.
    always_comb begin
        sum_d    = sum_q;
        count_d  = count_q;
        reject_d = 1'b0;
        push     = 1'b0;
        if (clear) begin
            sum_d   = '0;
            count_d = '0;
        end else if (undo) begin
            if (count_q != '0) begin
                sum_d   = sum_q - SUM_W'(hist_q[top_idx]);
                count_d = count_q - CW'(1);
            end else begin
                reject_d = 1'b1;
            end
        end else if (add) begin
            if (count_q == CW'(DEPTH) || add_total[SUM_W]) begin
                reject_d = 1'b1;
            end else begin
                push    = 1'b1;
                sum_d   = add_total[SUM_W-1:0];
                count_d = count_q + CW'(1);
            end
        end
    end

    // Accumulator state and the one-cycle reject pulse.
    always_ff @(posedge clk100mhz or posedge reset) begin
        if (reset) begin
            sum_q    <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    // LIFO history; entries above count are stale and never read.
    always_ff @(posedge clk100mhz) begin
        if (push) hist_q[push_idx] <= single_q;
    end

    bin2bcd_seq #(
        .SUM_W  (SUM_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk100mhz (clk100mhz),
        .reset     (reset),
        .bin       (sum_q),
        .bcd       (sum_bcd),
        .valid     (bcd_valid)
    );

    assign single = single_q;
    assign sum    = sum_q;
    assign count  = count_q;
    assign reject = reject_q;

endmodule
